// File: rtl/adc_drdy_monitor.sv
// Multi-channel ADC data-ready monitor: synchronizes and debounces active-low DRDY pins,
// emits one pulse per accepted falling edge, counts frames and flags missing frames.
module adc_drdy_monitor #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 1,
  parameter int unsigned TO_W        = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         drdy_n_async,
  input  logic [N_CH-1:0]         enable,
  input  logic [TO_W-1:0]         timeout_cycles,
  input  logic                    clear_stats,
  output logic [N_CH-1:0]         drdy_fall_pulse,
  output logic [N_CH-1:0]         armed,
  output logic [N_CH-1:0]         timeout_flag,
  output logic [N_CH*CNT_W-1:0]   frame_cnt
);

  localparam int unsigned FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned WARM = SYNC_STAGES + FILT_LEN;
  localparam int unsigned WU_W = $clog2(WARM + 1);

  logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  filt_q, filt_d;
  logic [N_CH-1:0][FC_W-1:0]        fcnt_q, fcnt_d;
  logic [WU_W-1:0]                  warm_q, warm_d;
  logic [N_CH-1:0]                  armed_q, armed_d;
  logic [N_CH-1:0]                  pulse_q, pulse_d;
  logic [N_CH-1:0]                  flag_q, flag_d;
  logic [N_CH-1:0][TO_W-1:0]        to_q, to_d;
  logic [N_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic                             to_en_c;
  logic [TO_W-1:0]                  to_last_c;

  // Next-state logic; every channel is evaluated identically and independently.
  always_comb begin
    warm_d    = (warm_q != '0) ? warm_q - WU_W'(1) : warm_q;
    to_en_c   = (timeout_cycles != '0);
    to_last_c = timeout_cycles - TO_W'(1);
    sync_d    = sync_q;
    filt_d    = filt_q;
    fcnt_d    = '0;
    armed_d   = '0;
    pulse_d   = '0;
    flag_d    = flag_q;
    to_d      = '0;
    cnt_d     = cnt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], drdy_n_async[i]};

      // A new level is accepted only after it has differed from filt for FILT_LEN cycles.
      if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
        if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
          filt_d[i] = sync_q[i][SYNC_STAGES-1];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FC_W'(1);
        end
      end

      armed_d[i] = enable[i] && (armed_q[i] || ((warm_q == '0) && filt_q[i]));
      pulse_d[i] = armed_q[i] && enable[i] && filt_q[i] && !filt_d[i];

      if (pulse_d[i] || !armed_q[i] || !to_en_c) begin
        to_d[i] = '0;
      end else if (to_q[i] != '1) begin
        to_d[i] = to_q[i] + TO_W'(1);
      end else begin
        to_d[i] = to_q[i];
      end

      if (to_en_c && armed_q[i] && !pulse_d[i] && (to_q[i] == to_last_c)) begin
        flag_d[i] = 1'b1;
      end
      cnt_d[i] = cnt_q[i] + CNT_W'(pulse_d[i]);

      // Clearing statistics takes priority over a coincident pulse.
      if (clear_stats) begin
        cnt_d[i]  = '0;
        flag_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      filt_q  <= '1;
      fcnt_q  <= '0;
      warm_q  <= WU_W'(WARM);
      armed_q <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      warm_q  <= warm_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign drdy_fall_pulse = pulse_q;
  assign armed           = armed_q;
  assign timeout_flag    = flag_q;
  assign frame_cnt       = cnt_q;

endmodule

// File: tb/tb_adc_drdy_monitor.sv
// Directed bench for adc_drdy_monitor: pulses are predicted into per-channel queues
// (expected cycle) when a fall is driven, and matched when the DUT pulses.
module tb_adc_drdy_monitor;
  localparam int unsigned N_CH  = 2;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned FILT  = 3;
  localparam int unsigned TO_W  = 16;
  localparam int unsigned CNT_W = 4;
  localparam int          LAT   = SYNC + FILT;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       drdy_n;
  logic [N_CH-1:0]       enable;
  logic [TO_W-1:0]       timeout_cycles;
  logic                  clear_stats;
  logic [N_CH-1:0]       pulse;
  logic [N_CH-1:0]       armed;
  logic [N_CH-1:0]       flag;
  logic [N_CH*CNT_W-1:0] frame_cnt;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  int q0[$];
  int q1[$];
  logic [CNT_W-1:0] exp_cnt0;
  logic [CNT_W-1:0] exp_cnt1;

  adc_drdy_monitor #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .TO_W(TO_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .drdy_n_async(drdy_n), .enable(enable),
    .timeout_cycles(timeout_cycles), .clear_stats(clear_stats),
    .drdy_fall_pulse(pulse), .armed(armed), .timeout_flag(flag), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge0();
    q0.push_back(cyc + LAT);
    drdy_n[0] = 1'b0;
    wait_cyc(7);
    drdy_n[0] = 1'b1;
    wait_cyc(7);
  endtask

  // Scoreboard: every observed pulse must match the oldest predicted cycle of its channel.
  always @(negedge clk) begin
    if (pulse[0] === 1'b1) begin
      if (q0.size() == 0) chk("pulse0_unexpected_at_cyc", 32'(cyc), 32'hFFFF_FFFF);
      else                chk("pulse0_cycle", 32'(cyc), 32'(q0.pop_front()));
    end
    if (pulse[1] === 1'b1) begin
      if (q1.size() == 0) chk("pulse1_unexpected_at_cyc", 32'(cyc), 32'hFFFF_FFFF);
      else                chk("pulse1_cycle", 32'(cyc), 32'(q1.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; drdy_n = 2'b10; enable = 2'b11; timeout_cycles = '0; clear_stats = 1'b0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    wait_cyc(3);
    chk("rst_armed", 32'(armed), 32'h0);
    chk("rst_pulse", 32'(pulse), 32'h0);
    chk("rst_flag", 32'(flag), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);

    // ch0 held low across reset must not arm or pulse until it has been high
    rst = 1'b0;
    wait_cyc(20);
    chk("ch0_low_not_armed", 32'(armed), 32'h2);
    drdy_n[0] = 1'b1;
    wait_cyc(10);
    chk("ch0_armed_after_high", 32'(armed), 32'h3);
    q0.push_back(cyc + LAT);
    drdy_n[0] = 1'b0;
    wait_cyc(8);
    exp_cnt0 = exp_cnt0 + 1'b1;
    chk("first_fall_cnt0", 32'(frame_cnt[3:0]), 32'(exp_cnt0));
    drdy_n[0] = 1'b1;
    wait_cyc(8);

    // 2-cycle glitch rejected, 3-cycle low accepted
    drdy_n[1] = 1'b0;
    wait_cyc(2);
    drdy_n[1] = 1'b1;
    wait_cyc(8);
    chk("glitch_cnt1", 32'(frame_cnt[7:4]), 32'(exp_cnt1));
    q1.push_back(cyc + LAT);
    drdy_n[1] = 1'b0;
    wait_cyc(3);
    drdy_n[1] = 1'b1;
    wait_cyc(8);
    exp_cnt1 = exp_cnt1 + 1'b1;
    chk("three_cycle_low_cnt1", 32'(frame_cnt[7:4]), 32'(exp_cnt1));

    // Missing-frame timeout of 10 cycles on both idle armed channels
    timeout_cycles = 16'd10;
    wait_cyc(9);
    chk("flag_before_timeout", 32'(flag), 32'h0);
    wait_cyc(1);
    chk("flag_at_timeout", 32'(flag), 32'h3);
    wait_cyc(20);
    chk("flag_sticky", 32'(flag), 32'h3);
    clear_stats = 1'b1;
    wait_cyc(1);
    clear_stats = 1'b0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    chk("flag_cleared", 32'(flag), 32'h0);
    chk("cnt_cleared", 32'(frame_cnt), 32'h0);
    wait_cyc(15);
    chk("flag_stays_clear", 32'(flag), 32'h0);
    timeout_cycles = '0;

    // 17 edges wrap a 4-bit counter to 1
    for (int k = 0; k < 17; k++) begin
      edge0();
      exp_cnt0 = exp_cnt0 + 1'b1;
    end
    chk("wrap_cnt0", 32'(frame_cnt[3:0]), 32'(exp_cnt0));
    chk("wrap_cnt0_is_1", 32'(frame_cnt[3:0]), 32'h1);

    // clear_stats coincident with the 18th pulse
    q0.push_back(cyc + LAT);
    drdy_n[0] = 1'b0;
    wait_cyc(LAT - 1);
    clear_stats = 1'b1;
    wait_cyc(1);
    clear_stats = 1'b0;
    exp_cnt0 = '0;
    chk("clear_wins_cnt0", 32'(frame_cnt[3:0]), 32'(exp_cnt0));
    wait_cyc(1);
    chk("coincident_pulse_seen", 32'(q0.size()), 32'h0);
    drdy_n[0] = 1'b1;
    wait_cyc(7);

    // Disabled channel ignores toggles; re-enable while low waits for a high level
    enable[1] = 1'b0;
    wait_cyc(1);
    chk("disarm_ch1", 32'(armed), 32'h1);
    for (int k = 0; k < 2; k++) begin
      drdy_n[1] = 1'b0;
      wait_cyc(7);
      drdy_n[1] = 1'b1;
      wait_cyc(7);
    end
    chk("disabled_cnt1", 32'(frame_cnt[7:4]), 32'(exp_cnt1));
    drdy_n[1] = 1'b0;
    wait_cyc(8);
    enable[1] = 1'b1;
    wait_cyc(8);
    chk("no_rearm_while_low", 32'(armed), 32'h1);
    drdy_n[1] = 1'b1;
    wait_cyc(8);
    chk("rearm_after_high", 32'(armed), 32'h3);
    q1.push_back(cyc + LAT);
    drdy_n[1] = 1'b0;
    wait_cyc(8);
    exp_cnt1 = exp_cnt1 + 1'b1;
    chk("rearm_fall_cnt1", 32'(frame_cnt[7:4]), 32'(exp_cnt1));
    drdy_n[1] = 1'b1;
    wait_cyc(8);

    // Reset one cycle before an expected pulse, then warmup is honored
    drdy_n[0] = 1'b0;
    wait_cyc(LAT - 1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    chk("rst_mid_armed", 32'(armed), 32'h0);
    chk("rst_mid_cnt", 32'(frame_cnt), 32'h0);
    wait_cyc(LAT);
    chk("warmup_hold", 32'(armed), 32'h0);
    wait_cyc(1);
    chk("warmup_done", 32'(armed), 32'h2);
    drdy_n[0] = 1'b1;
    wait_cyc(8);
    chk("post_rst_arm_ch0", 32'(armed), 32'h3);
    q0.push_back(cyc + LAT);
    drdy_n[0] = 1'b0;
    wait_cyc(8);
    exp_cnt0 = exp_cnt0 + 1'b1;
    chk("post_rst_cnt0", 32'(frame_cnt[3:0]), 32'(exp_cnt0));
    wait_cyc(2);
    chk("pending_q0", 32'(q0.size()), 32'h0);
    chk("pending_q1", 32'(q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adc_drdy_monitor.md
ADC_DRDY_MONITOR -- requirements
Module: adc_drdy_monitor

Interface
REQ-001 Parameter N_CH, default 8: number of independent active-low DRDY channels.
REQ-002 Parameter SYNC_STAGES, default 2, legal >=2: synchronizer flop depth.
REQ-003 Parameter FILT_LEN, default 1, legal >=1: consecutive cycles a new level must hold before it is accepted.
REQ-004 Parameter TO_W, default 16: width of the timeout threshold and timeout counters.
REQ-005 Parameter CNT_W, default 16: width of each per-channel frame counter.
REQ-006 clk  in  1  clock; all logic is on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 drdy_n_async  in  N_CH  asynchronous DRDY pins, active low.
REQ-009 enable  in  N_CH  per-channel enable.
REQ-010 timeout_cycles  in  TO_W  missing-frame threshold in clk cycles; 0 disables timeout detection.
REQ-011 clear_stats  in  1  single-cycle clear of frame counters and timeout flags.
REQ-012 drdy_fall_pulse  out  N_CH  one-cycle pulse per accepted falling edge.
REQ-013 armed  out  N_CH  channel has seen DRDY high post-warmup and is enabled.
REQ-014 timeout_flag  out  N_CH  sticky missing-frame flag.
REQ-015 frame_cnt  out  N_CH*CNT_W  per-channel accepted-edge counts; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-016 Each channel SHALL use a SYNC_STAGES-deep synchronizer chain; its last stage is s[i].
REQ-017 Filter per channel: if s equals filt, the filter counter SHALL clear; otherwise it SHALL increment; on the cycle it would reach FILT_LEN, filt SHALL take s and the counter SHALL clear.
REQ-018 A single warmup counter SHALL load SYNC_STAGES+FILT_LEN at reset and decrement to 0; arming SHALL NOT occur while it is nonzero.
REQ-019 armed[i] SHALL set when warmup==0, enable[i]==1 and filt[i]==1; it SHALL clear the cycle after enable[i] falls, and SHALL re-arm only via REQ-019's set condition.
REQ-020 drdy_fall_pulse[i] SHALL be registered and SHALL be high for exactly the one cycle in which filt[i] transitions 1->0, qualified by armed[i] && enable[i].
REQ-021 Latency: a clean low step on drdy_n_async SHALL produce its pulse SYNC_STAGES+FILT_LEN cycles later.
REQ-022 Glitches shorter than FILT_LEN synchronized cycles SHALL produce no pulse and no filt change.
REQ-023 frame_cnt[i] SHALL increment by 1 on each pulse and wrap modulo 2^CNT_W.
REQ-024 Timeout counter[i] SHALL clear on pulse, when not armed, or when timeout_cycles==0; otherwise it SHALL increment, saturating at all-ones.
REQ-025 timeout_flag[i] SHALL set when the counter equals timeout_cycles-1 while armed and no pulse is present; it SHALL stay set until clear_stats or rst.
REQ-026 clear_stats SHALL zero all frame_cnt and timeout_flag; when it coincides with a pulse, clear wins (count=0, flag=0), and the pulse still outputs.
REQ-027 Channels SHALL be fully independent except for the shared warmup, timeout_cycles and clear_stats.

Reset
REQ-028 On rst: sync chains and filt = all 1, filter and timeout counters = 0, warmup reloaded, armed = 0, drdy_fall_pulse = 0, timeout_flag = 0, frame_cnt = 0.
REQ-029 rst mid-pulse or mid-filter SHALL discard in-progress state; no pulse SHALL follow reset until re-arming.
REQ-030 DRDY held low through reset SHALL produce no pulse until a high level is seen and armed, then a genuine fall.

Verification
REQ-031 N_CH=2, SYNC_STAGES=2, FILT_LEN=3: ch0 held low across reset, released high 20 cycles later, then falls -> exactly one pulse 5 cycles after the fall, and none before it.
REQ-032 FILT_LEN=3: 2-cycle low glitch on ch1 -> no pulse and frame_cnt[1] unchanged; 3-cycle low -> one pulse.
REQ-033 timeout_cycles=10, ch0 armed, no edges -> timeout_flag[0] sets on the 10th armed cycle, counter saturates; then clear_stats -> flag 0.
REQ-034 CNT_W=4: 17 edges on ch0 -> frame_cnt[0]=1; clear_stats on the same cycle as the 18th pulse -> count 0 and pulse still seen.
REQ-035 enable[1] dropped while DRDY toggles -> no pulses and armed[1]=0; re-enable with DRDY low -> no pulse until high then falling.
REQ-036 rst asserted 1 cycle before an expected pulse -> no pulse; warmup of SYNC_STAGES+FILT_LEN cycles is honored after release.
